// File: rtl/spi_datapath.sv
// ---------------------------------------------------------------------------
// spi_datapath
//   Byte-wide SPI datapath: TX FIFO, RX FIFO, MOSI shift register and MISO
//   capture register. SCLK is generated elsewhere (the controller); this
//   block only watches it for edges and shifts/samples accordingly.
//
//   Ports
//     clk, rst_n                 system clock, asynchronous active-low reset
//     tx_wdata_i, tx_push_i      bus write into the TX FIFO
//     tx_full_o, tx_empty_o      TX FIFO status (tx_empty_o goes to controller)
//     rx_rdata_o, rx_pop_i       RX FIFO head (first-word-fall-through) / pop
//     rx_empty_o, rx_full_o      RX FIFO status
//     rx_overflow_o              sticky: RX write lost because RX was full
//     clr_overflow_i             clears rx_overflow_o
//     tx_fifo_read_i             controller: start a frame (load shifter)
//     rx_fifo_write_i            controller: frame done, store captured word
//     spi_clk_i                  SCLK as driven by the controller
//     spi_clk_phase_i            CPHA
//     spi_clk_polarity_i         CPOL (SCLK idle level)
//     spi_data_size_i            bits per frame, 0 or >8 means 8
//     spi_mosi_o, spi_miso_i     serial data out / in (MISO pre-synchronised)
// ---------------------------------------------------------------------------

// Synchronous FWFT FIFO with wrap-bit pointers. Callers pass already
// qualified enables, so overflow/underflow policy lives in the parent.
// Storage is intentionally not reset.
module spi_datapath_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] wdata,
   input  logic       wr_en,
   input  logic       rd_en,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);
   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wdata;
   end

   // Head word is visible without a pop (first-word-fall-through).
   assign rdata = mem[rd_ptr_reg[AW-1:0]];
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty = (wr_ptr_reg == rd_ptr_reg);
endmodule

module spi_datapath #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_wdata_i,
   input  logic       tx_push_i,
   output logic       tx_full_o,
   output logic       tx_empty_o,
   output logic [7:0] rx_rdata_o,
   input  logic       rx_pop_i,
   output logic       rx_empty_o,
   output logic       rx_full_o,
   output logic       rx_overflow_o,
   input  logic       clr_overflow_i,
   input  logic       tx_fifo_read_i,
   input  logic       rx_fifo_write_i,
   input  logic       spi_clk_i,
   input  logic       spi_clk_phase_i,
   input  logic       spi_clk_polarity_i,
   input  logic [3:0] spi_data_size_i,
   output logic       spi_mosi_o,
   input  logic       spi_miso_i
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   // FIFO handshakes
   logic [7:0] tx_head;
   logic       tx_wr_en;
   logic       tx_rd_en;
   logic       rx_wr_en;
   logic       rx_rd_en;
   logic [7:0] rx_wdata;

   // Frame geometry
   logic [3:0] frame_len;
   logic [7:0] frame_mask;
   logic [7:0] tx_aligned;

   // SCLK edge detection
   logic sclk_d_reg;
   logic leading_edge;
   logic trailing_edge;
   logic sample_edge;
   logic shift_edge;

   // Shifter state
   logic [7:0] tx_sr_reg,      tx_sr_next;
   logic [7:0] rx_sr_reg,      rx_sr_next;
   logic [7:0] rx_sampled;
   logic [3:0] bit_cnt_reg,    bit_cnt_next;
   logic       first_edge_reg, first_edge_next;
   logic       overflow_reg,   overflow_next;

   // -----------------------------------------------------------------------
   // FIFOs
   // -----------------------------------------------------------------------
   // A TX push on a full FIFO is lost even if a read happens the same cycle.
   assign tx_wr_en = tx_push_i && !tx_full_o;
   assign tx_rd_en = tx_fifo_read_i && !tx_empty_o;
   assign rx_rd_en = rx_pop_i && !rx_empty_o;
   // A simultaneous pop frees the slot, so a write on a full RX still lands.
   assign rx_wr_en = rx_fifo_write_i && (!rx_full_o || rx_rd_en);

   spi_datapath_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wdata (tx_wdata_i),
      .wr_en (tx_wr_en),
      .rd_en (tx_rd_en),
      .rdata (tx_head),
      .full  (tx_full_o),
      .empty (tx_empty_o)
   );

   spi_datapath_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wdata (rx_wdata),
      .wr_en (rx_wr_en),
      .rd_en (rx_rd_en),
      .rdata (rx_rdata_o),
      .full  (rx_full_o),
      .empty (rx_empty_o)
   );

   // -----------------------------------------------------------------------
   // Frame geometry
   // -----------------------------------------------------------------------
   always_comb begin
      frame_len = spi_data_size_i;
      if (spi_data_size_i == 4'd0 || spi_data_size_i > 4'd8) frame_len = 4'd8;
   end

   // Low frame_len bits set; used to clean the captured word.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_mask
         assign frame_mask[gi] = (frame_len > 4'(gi));
      end
   endgenerate

   // Left-justify the TX word so its MSB (bit N-1) leaves first via bit 7.
   assign tx_aligned = tx_head << (4'd8 - frame_len);

   // -----------------------------------------------------------------------
   // SCLK edges, relative to the idle level given by CPOL
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sclk_d_reg <= spi_clk_polarity_i;
      else        sclk_d_reg <= spi_clk_i;
   end

   assign leading_edge  = (sclk_d_reg == spi_clk_polarity_i) &&
                          (spi_clk_i  != spi_clk_polarity_i);
   assign trailing_edge = (sclk_d_reg != spi_clk_polarity_i) &&
                          (spi_clk_i  == spi_clk_polarity_i);

   // With CPHA=1 the first leading edge of a frame only launches bit N-1,
   // which is already on MOSI after the load, so it must not shift.
   assign sample_edge = spi_clk_phase_i ? trailing_edge : leading_edge;
   assign shift_edge  = spi_clk_phase_i ? (leading_edge && !first_edge_reg)
                                        : trailing_edge;

   // -----------------------------------------------------------------------
   // Shifter next state
   // -----------------------------------------------------------------------
   assign rx_sampled = sample_edge ? {rx_sr_reg[6:0], spi_miso_i} : rx_sr_reg;
   // The stored word includes a sample taken in the same cycle as the write.
   assign rx_wdata   = rx_sampled & frame_mask;

   always_comb begin
      tx_sr_next      = tx_sr_reg;
      rx_sr_next      = rx_sampled;
      bit_cnt_next    = bit_cnt_reg;
      first_edge_next = first_edge_reg;

      if (sample_edge && bit_cnt_reg < 4'd8) bit_cnt_next = bit_cnt_reg + 4'd1;
      if (spi_clk_phase_i && leading_edge)    first_edge_next = 1'b0;
      if (shift_edge)                         tx_sr_next = {tx_sr_reg[6:0], 1'b0};

      // A frame start wins over any edge in the same cycle. An underrun
      // frame still restarts capture; it just sends all ones.
      if (tx_fifo_read_i) begin
         tx_sr_next      = tx_empty_o ? 8'hFF : tx_aligned;
         rx_sr_next      = 8'h00;
         bit_cnt_next    = 4'd0;
         first_edge_next = 1'b1;
      end
   end

   // Set has priority over clear so a lost word is never hidden.
   always_comb begin
      overflow_next = overflow_reg;
      if (clr_overflow_i)                overflow_next = 1'b0;
      if (rx_fifo_write_i && !rx_wr_en)  overflow_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sr_reg      <= 8'hFF;
         rx_sr_reg      <= 8'h00;
         bit_cnt_reg    <= 4'd0;
         first_edge_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         tx_sr_reg      <= tx_sr_next;
         rx_sr_reg      <= rx_sr_next;
         bit_cnt_reg    <= bit_cnt_next;
         first_edge_reg <= first_edge_next;
         overflow_reg   <= overflow_next;
      end
   end

   assign spi_mosi_o    = tx_sr_reg[7];
   assign rx_overflow_o = overflow_reg;
endmodule

// File: tb/tb_spi_datapath.sv
// ---------------------------------------------------------------------------
// tb_spi_datapath
//   Scoreboard bench for spi_datapath. The bench plays the SPI controller
//   (SCLK generation, frame start/end strobes) and keeps a queue-level model
//   of both FIFOs. Expected MOSI bits and RX words are pushed into queues
//   when stimulus is issued; a separate monitor pops and compares them when
//   the DUT presents them (sample points and RX pops).
// ---------------------------------------------------------------------------
module tb_spi_datapath;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_wdata_i = 8'h00;
   logic       tx_push_i = 1'b0;
   logic       tx_full_o, tx_empty_o;
   logic [7:0] rx_rdata_o;
   logic       rx_pop_i = 1'b0;
   logic       rx_empty_o, rx_full_o, rx_overflow_o;
   logic       clr_overflow_i = 1'b0;
   logic       tx_fifo_read_i = 1'b0;
   logic       rx_fifo_write_i = 1'b0;
   logic       spi_clk_i = 1'b0;
   logic       spi_clk_phase_i = 1'b0;
   logic       spi_clk_polarity_i = 1'b0;
   logic [3:0] spi_data_size_i = 4'd8;
   logic       spi_mosi_o;
   logic       spi_miso_i;

   logic loopback = 1'b0;
   logic miso_drv = 1'b0;
   assign spi_miso_i = loopback ? spi_mosi_o : miso_drv;

   always #5 clk = ~clk;

   spi_datapath #(.FIFO_DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .tx_wdata_i         (tx_wdata_i),
      .tx_push_i          (tx_push_i),
      .tx_full_o          (tx_full_o),
      .tx_empty_o         (tx_empty_o),
      .rx_rdata_o         (rx_rdata_o),
      .rx_pop_i           (rx_pop_i),
      .rx_empty_o         (rx_empty_o),
      .rx_full_o          (rx_full_o),
      .rx_overflow_o      (rx_overflow_o),
      .clr_overflow_i     (clr_overflow_i),
      .tx_fifo_read_i     (tx_fifo_read_i),
      .rx_fifo_write_i    (rx_fifo_write_i),
      .spi_clk_i          (spi_clk_i),
      .spi_clk_phase_i    (spi_clk_phase_i),
      .spi_clk_polarity_i (spi_clk_polarity_i),
      .spi_data_size_i    (spi_data_size_i),
      .spi_mosi_o         (spi_mosi_o),
      .spi_miso_i         (spi_miso_i)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   byte unsigned tx_q[$];       // words waiting in TX
   byte unsigned exp_rx_q[$];   // words expected out of RX, in order
   bit           exp_mosi_q[$]; // MOSI bits expected at sample points
   bit           ovf_model = 1'b0;
   byte unsigned last_rx = 8'h00; // word captured by the most recent frame
   bit           mon_mosi = 1'b0; // next clock edge is a sample edge

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queues.
   always @(negedge clk) begin
      if (rst_n && rx_pop_i && !rx_empty_o) begin
         checks++;
         if (exp_rx_q.size() == 0) begin
            failures++;
            $display("FAIL rx_pop_unexpected actual=%0h expected=none", rx_rdata_o);
         end else begin
            automatic byte unsigned e = exp_rx_q.pop_front();
            if (rx_rdata_o !== e) begin
               failures++;
               $display("FAIL rx_data actual=%0h expected=%0h", rx_rdata_o, e);
            end
         end
      end
      if (rst_n && mon_mosi) begin
         checks++;
         if (exp_mosi_q.size() == 0) begin
            failures++;
            $display("FAIL mosi_unexpected actual=%0b expected=none", spi_mosi_o);
         end else begin
            automatic bit eb = exp_mosi_q.pop_front();
            if (spi_mosi_o !== eb) begin
               failures++;
               $display("FAIL mosi_bit actual=%0b expected=%0b", spi_mosi_o, eb);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_tx_empty"}, int'(tx_empty_o),    int'(tx_q.size() == 0));
      chk({tag, "_tx_full"},  int'(tx_full_o),     int'(tx_q.size() == DEPTH));
      chk({tag, "_rx_empty"}, int'(rx_empty_o),    int'(exp_rx_q.size() == 0));
      chk({tag, "_rx_full"},  int'(rx_full_o),     int'(exp_rx_q.size() == DEPTH));
      chk({tag, "_overflow"}, int'(rx_overflow_o), int'(ovf_model));
   endtask

   task automatic push_tx(input byte unsigned w);
      tx_wdata_i = w;
      tx_push_i  = 1'b1;
      if (tx_q.size() < DEPTH) tx_q.push_back(w);
      tick();
      tx_push_i = 1'b0;
      $display("push tx=%02h accepted=%0d level=%0d", w, tx_q.size() <= DEPTH, tx_q.size());
   endtask

   task automatic rx_write(input bit with_pop, input bit with_clr);
      bit popping, accept;
      popping = with_pop && (exp_rx_q.size() > 0);
      accept  = (exp_rx_q.size() < DEPTH) || popping;
      rx_fifo_write_i = 1'b1;
      rx_pop_i        = with_pop;
      clr_overflow_i  = with_clr;
      if (with_clr) ovf_model = 1'b0;
      if (accept) exp_rx_q.push_back(last_rx);
      else        ovf_model = 1'b1;
      tick();
      rx_fifo_write_i = 1'b0;
      rx_pop_i        = 1'b0;
      clr_overflow_i  = 1'b0;
      $display("rx_write word=%02h pop=%0d clr=%0d accepted=%0d", last_rx, with_pop, with_clr, accept);
   endtask

   task automatic rx_pop();
      rx_pop_i = 1'b1;
      tick();
      rx_pop_i = 1'b0;
   endtask

   task automatic drain_rx();
      for (int g = 0; g < 2 * DEPTH && exp_rx_q.size() > 0; g++) rx_pop();
      tick();
   endtask

   // One controller-driven frame. abort_bits >= 0 stops after that many bits.
   task automatic run_frame(input bit cpol, input bit cpha, input logic [3:0] size,
                            input bit loop, input byte unsigned miso_pat,
                            input bit push_with_read, input byte unsigned push_val,
                            input int abort_bits);
      int n;
      bit has, accept, b, mb, aborted;
      byte unsigned word, rxw;
      n = (size == 4'd0 || size > 4'd8) ? 8 : int'(size);
      spi_clk_polarity_i = cpol;
      spi_clk_phase_i    = cpha;
      spi_data_size_i    = size;
      spi_clk_i          = cpol;
      loopback           = loop;
      tick();
      tick();
      // Model: frame word is the TX head, or all ones on underrun.
      accept = tx_q.size() < DEPTH;
      has    = tx_q.size() > 0;
      word   = has ? tx_q.pop_front() : 8'hFF;
      if (push_with_read && accept) tx_q.push_back(push_val);
      rxw = 8'h00;
      for (int i = 0; i < n; i++) begin
         b  = has ? word[n-1-i] : 1'b1;
         mb = loop ? b : miso_pat[n-1-i];
         exp_mosi_q.push_back(b);
         rxw = byte'((rxw << 1) | mb);
      end
      tx_fifo_read_i = 1'b1;
      if (push_with_read) begin
         tx_wdata_i = push_val;
         tx_push_i  = 1'b1;
      end
      tick();
      tx_fifo_read_i = 1'b0;
      tx_push_i      = 1'b0;
      aborted = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == abort_bits) begin
            aborted = 1'b1;
            break;
         end
         miso_drv  = miso_pat[n-1-i];
         spi_clk_i = ~cpol;
         mon_mosi  = ~cpha;
         tick();
         mon_mosi = 1'b0;
         tick();
         spi_clk_i = cpol;
         mon_mosi  = cpha;
         tick();
         mon_mosi = 1'b0;
         tick();
      end
      if (aborted) begin
         for (int k = abort_bits; k < n; k++) void'(exp_mosi_q.pop_back());
         $display("frame aborted cpol=%0d cpha=%0d n=%0d after=%0d", cpol, cpha, n, abort_bits);
      end else begin
         last_rx = rxw;
         $display("frame cpol=%0d cpha=%0d n=%0d tx=%02h underrun=%0d rx=%02h",
                  cpol, cpha, n, word, !has, rxw);
      end
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_status("reset");
      chk("reset_mosi", int'(spi_mosi_o), 1);

      // Loopback CPOL=0 CPHA=0 N=8 with 0xA5
      push_tx(8'hA5);
      check_status("push_a5");
      run_frame(1'b0, 1'b0, 4'd8, 1'b1, 8'h00, 1'b0, 8'h00, -1);
      check_status("after_a5");
      rx_write(1'b0, 1'b0);
      rx_pop();
      tick();
      check_status("popped_a5");

      // CPHA=1 CPOL=1 N=5, 0x13 out, MISO 1,1,0,0,1 in
      push_tx(8'h13);
      run_frame(1'b1, 1'b1, 4'd5, 1'b0, 8'h19, 1'b0, 8'h00, -1);
      chk("cpha1_rx_model", int'(last_rx), 8'h19);
      rx_write(1'b0, 1'b0);
      drain_rx();

      // Five pushes into a 4-deep TX, then four frames
      for (int i = 1; i <= 5; i++) begin
         push_tx(byte'(i));
         check_status("tx_fill");
      end
      for (int i = 0; i < 4; i++) begin
         run_frame(1'b0, 1'b0, 4'd8, 1'b1, 8'h00, 1'b0, 8'h00, -1);
         rx_write(1'b0, 1'b0);
      end
      check_status("tx_drained");

      // RX overflow: one more write than fits
      rx_write(1'b0, 1'b0);
      check_status("rx_overflow");
      rx_write(1'b0, 1'b1);            // clear and set together: set wins
      check_status("ovf_set_wins");
      rx_write(1'b0, 1'b0);
      tick();
      clr_overflow_i = 1'b1;
      ovf_model      = 1'b0;
      tick();
      clr_overflow_i = 1'b0;
      check_status("ovf_cleared");
      rx_write(1'b1, 1'b0);            // write + pop on full
      tick();
      check_status("write_pop_full");
      drain_rx();
      check_status("rx_drained");

      // Underrun frame: MOSI stays high, TX pointers untouched
      run_frame(1'b0, 1'b0, 4'd8, 1'b0, 8'h3C, 1'b0, 8'h00, -1);
      check_status("underrun");
      // Push in the same cycle as an underrun read: push survives
      run_frame(1'b0, 1'b0, 4'd6, 1'b0, 8'h2A, 1'b1, 8'h5A, -1);
      check_status("push_on_underrun");
      run_frame(1'b0, 1'b1, 4'd8, 1'b1, 8'h00, 1'b0, 8'h00, -1);
      rx_write(1'b0, 1'b0);
      drain_rx();

      // Reset three bits into a frame
      push_tx(8'hC3);
      push_tx(8'h77);
      rx_write(1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 4'd8, 1'b1, 8'h00, 1'b0, 8'h00, 3);
      #2;
      rst_n = 1'b0;
      #1;
      tx_q.delete();
      exp_rx_q.delete();
      ovf_model = 1'b0;
      last_rx   = 8'h00;
      check_status("mid_reset");
      chk("mid_reset_mosi", int'(spi_mosi_o), 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      push_tx(8'h96);
      run_frame(1'b0, 1'b0, 4'd8, 1'b1, 8'h00, 1'b0, 8'h00, -1);
      rx_write(1'b0, 1'b0);
      drain_rx();
      check_status("post_reset");

      // Randomised frames
      for (int it = 0; it < 30; it++) begin
         int npush;
         npush = $urandom_range(0, 2);
         for (int p = 0; p < npush; p++) push_tx(8'($urandom));
         run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   8'($urandom), ($urandom_range(0, 4) == 0), 8'($urandom), -1);
         rx_write(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
         tick();
         check_status("random");
         if ($urandom_range(0, 1) == 1) rx_pop();
      end
      drain_rx();
      check_status("final");
      chk("final_rx_queue", exp_rx_q.size(), 0);
      chk("final_mosi_queue", exp_mosi_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_datapath.md
SPI_DATAPATH -- requirements
Module: spi_datapath

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power of two ≥2; TX and RX FIFO entries.
REQ-002 SHALL have port clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports tx_wdata_i  in  8  bus write data; tx_push_i  in  1  write strobe.
REQ-005 SHALL have ports tx_full_o  out  1  and tx_empty_o  out  1  TX FIFO status; tx_empty_o feeds the controller.
REQ-006 SHALL have ports rx_rdata_o  out  8  RX head data; rx_pop_i  in  1  read strobe.
REQ-007 SHALL have ports rx_empty_o  out  1  and rx_full_o  out  1  RX FIFO status.
REQ-008 SHALL have ports rx_overflow_o  out  1  sticky error; clr_overflow_i  in  1  clear.
REQ-009 SHALL have ports tx_fifo_read_i  in  1  and rx_fifo_write_i  in  1  controller strobes.
REQ-010 SHALL have ports spi_clk_i  in  1  SCLK from the controller; spi_clk_phase_i  in  1; spi_clk_polarity_i  in  1; spi_data_size_i  in  4  bits per frame.
REQ-011 SHALL have ports spi_mosi_o  out  1  serial out; spi_miso_i  in  1  serial in (already synchronised).

Function
REQ-012 Both FIFOs SHALL be synchronous, first-word-fall-through, with log2(FIFO_DEPTH)+1-bit wrapping read/write pointers; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-013 tx_push_i when TX full SHALL be dropped with no pointer change; when not full, the word SHALL be stored and tx_empty_o SHALL deassert on the next cycle.
REQ-014 rx_pop_i when RX empty SHALL be ignored; rx_rdata_o SHALL hold its value.
REQ-015 Effective frame length N SHALL be 8 when spi_data_size_i is 0 or >8, else spi_data_size_i.
REQ-016 On tx_fifo_read_i with TX non-empty: shift register <= TX head << (8-N), TX read pointer advances, bit counter clears, rx shift register clears, first_edge flag sets.
REQ-017 On tx_fifo_read_i with TX empty: shift register SHALL load 8'hFF, no pointer change.
REQ-018 spi_mosi_o SHALL equal shift register bit 7 combinationally.
REQ-019 SCLK edges SHALL be detected against a one-cycle delayed copy of spi_clk_i: leading = transition away from polarity, trailing = transition back to polarity.
REQ-020 CPHA=0: sample edge = leading, shift edge = trailing.
REQ-021 CPHA=1: shift edge = leading, sample edge = trailing; the first leading edge after a load SHALL NOT shift and SHALL clear first_edge.
REQ-022 Shift edge: shift register <= {sr[6:0],1'b0}.
REQ-023 Sample edge: rx shift register <= {rx[6:0], spi_miso_i}; bit counter increments, saturating at 8.
REQ-024 On rx_fifo_write_i: the RX FIFO SHALL receive the rx shift register value after any sample in the same cycle, masked to its low N bits, upper bits zero.
REQ-025 rx_fifo_write_i when RX full without simultaneous rx_pop_i: word dropped, rx_overflow_o set.
REQ-026 rx_fifo_write_i and rx_pop_i together on full RX: both SHALL occur; no overflow.
REQ-027 rx_overflow_o SHALL clear on clr_overflow_i; a simultaneous set SHALL take priority.
REQ-028 tx_push_i and tx_fifo_read_i in the same cycle SHALL both take effect; a read on an empty FIFO SHALL follow REQ-017 and the push SHALL be stored.
REQ-029 A change of configuration inputs mid-frame is out of scope; the controller holds them stable while busy.

Reset
REQ-030 On rst_n low, asynchronously:
  - all pointers = 0
  - tx_empty_o = 1, rx_empty_o = 1, tx_full_o = 0, rx_full_o = 0, rx_overflow_o = 0
  - shift register = 8'hFF, so spi_mosi_o = 1
  - rx shift register = 0, bit counter = 0, first_edge = 0
  - delayed SCLK = spi_clk_polarity_i sampled at reset release
REQ-031 Reset mid-frame SHALL discard all FIFO contents and partial frames; FIFO RAM contents SHALL not be reset.

Verification
REQ-032 Loopback, CPOL=0 CPHA=0, N=8: push 0xA5, MISO tied to MOSI, run one frame -> MOSI bits 1,0,1,0,0,1,0,1; RX holds 0xA5; tx_empty_o=1.
REQ-033 CPHA=1 CPOL=1, N=5: push 0x13 with MISO driving 1,1,0,0,1 -> MOSI 1,0,0,1,1, changing only after the 2nd leading edge onward; RX word = 0x19.
REQ-034 Push 5 words with FIFO_DEPTH=4 -> tx_full_o after the 4th push, 5th dropped; four frames transmit words 1-4 in order.
REQ-035 Five rx_fifo_write_i pulses with no pop -> rx_full_o=1, rx_overflow_o=1. Then write+pop in the same cycle -> no new overflow; clr_overflow_i -> rx_overflow_o=0.
REQ-036 tx_fifo_read_i with TX empty -> MOSI stays 1 for all of the frame; pointers unchanged.
REQ-037 Assert rst_n low mid-frame after 3 bits -> all status outputs return to REQ-030 values within the same cycle; the next frame transmits correctly.
